jtag_dbg_ocimem_ctrl: RTL
=========================

// Module: jtag_dbg_ocimem_ctrl
// PURPOSE
// - Debug-memory controller directly downstream of the JTAG debug wrapper: it consumes jdo and the
//   ocimem take_* strobes, and returns MonDReg, monitor_ready and monitor_error to that wrapper.
// - Owns a 2^ADDR_W x 32 single-port sync RAM (1-cycle read), shared between JTAG and a CPU Avalon-MM slave.
// - JTAG has priority over the CPU; one pending JTAG request is buffered while a CPU access is in flight.
// PARAMETERS
// - ADDR_W      8   word-address width; range 1..17
// - RESET_ADDR  0   reset value of MonAReg
// PORTS
// - clk              in   1       system clock; the only clock
// - reset            in   1       synchronous, active-high reset
// - jdo              in   38      JTAG data: addr=jdo[17+:ADDR_W], rd_flag=jdo[34], err_clr=jdo[35], wdata=jdo[34:3]
// - take_action_ocimem_a     in  1   load address; read at new address if rd_flag=1; clear error if err_clr=1
// - take_action_ocimem_b     in  1   write wdata at MonAReg
// - take_no_action_ocimem_a  in  1   read at MonAReg
// - MonDReg          out  32      last JTAG read data
// - MonAReg          out  ADDR_W  current JTAG word address
// - monitor_ready    out  1       1 = no JTAG op active or pending
// - monitor_error    out  1       sticky: a JTAG request was dropped
// - cpu_address      in   ADDR_W  CPU word address
// - cpu_read / cpu_write  in  1   Avalon strobes; held until waitrequest=0
// - cpu_writedata    in   32      CPU write data
// - cpu_byteenable   in   4       CPU byte lanes
// - cpu_readdata     out  32      registered; valid when waitrequest=0
// - cpu_waitrequest  out  1       = (cpu_read|cpu_write) & (state!=CACK)
// BEHAVIOUR
// - Reset values: MonDReg=0, MonAReg=RESET_ADDR, monitor_ready=1, monitor_error=0, cpu_readdata=0,
//   state=IDLE, pending empty. Reset mid-op aborts the op; the RAM write in that cycle is suppressed.
// - JTAG request sources, in priority order: pending > a > b > no_action_a. Two or more strobes in
//   one cycle: execute only the highest-priority strobe and set monitor_error.
// - FSM states: IDLE, JRD, JWR, CRD, CACK.
//   - IDLE + JTAG read  -> issue RAM read at addr -> JRD.
//   - JRD: MonDReg<=q; MonAReg<=addr+1 -> IDLE.
//   - IDLE + b -> RAM write, all lanes -> JWR.
//   - JWR: MonAReg<=MonAReg+1 -> IDLE.
//   - IDLE + a with rd_flag=0 -> MonAReg<=addr; stays IDLE; 1-cycle op.
//   - IDLE + cpu_read, no JTAG request -> RAM read -> CRD.
//   - CRD: cpu_readdata<=q -> CACK.
//   - IDLE + cpu_write, no JTAG request -> byte-masked RAM write -> CACK.
//   - CACK: waitrequest=0 this cycle -> IDLE.
// - CPU latency: read completes on the 3rd cycle, write on the 2nd cycle (waitrequest low in CACK).
// - monitor_ready falls the cycle after a JTAG strobe is accepted or buffered. It rises one cycle
//   after JRD or JWR completes, or the cycle after an address-only a op.
// - Strobe arrives during CRD/CACK: capture {type,jdo} into pending (1-deep); it executes from IDLE
//   next, ahead of any CPU request. Strobe arrives during JRD/JWR, or while pending is full: drop it
//   and set monitor_error.
// - monitor_error clears only on an accepted a with err_clr=1. If a set event occurs in the same
//   cycle, set wins.
// - MonAReg increment wraps 2^ADDR_W-1 -> 0. The CPU address never auto-increments.
// CONFIGURATION
// - OCIMEM_INIT_CLEAR_EN defined:
//   - After reset, state CLR writes 0 to addresses 0..2^ADDR_W-1, one per cycle (2^ADDR_W cycles).
//   - During CLR: monitor_ready=0 and cpu_waitrequest=(cpu_read|cpu_write); JTAG strobes are dropped
//     and set monitor_error. Then -> IDLE.
// - OCIMEM_INIT_CLEAR_EN undefined: no CLR state; IDLE on the first cycle after reset; RAM contents
//   undefined until written.
// TESTING
// - Address load: a addr=0x10,rd=0 -> MonAReg=0x10 next cycle.
//   Write: b wdata=0xDEADBEEF -> MonAReg=0x11.
//   Readback: a addr=0x10,rd=1 -> MonDReg=0xDEADBEEF 2 cycles after the strobe, MonAReg=0x11, ready=1.
// - Wrap: a addr=0xFF, b 0x1234 -> MonAReg=0x00; no_action_a -> reads addr 0x00, MonAReg=0x01.
// - Byte write: cpu_write addr=0x10, be=4'b0010, data=0x0000AB00 -> JTAG read of 0x10 = 0xDEADABEF.
//   CPU read: cpu_read of 0x10 -> waitrequest low on cycle 3, readdata=0xDEADABEF.
// - Collision: a(rd=1) and cpu_read in the same IDLE cycle -> JTAG runs first; CPU completes 2 cycles later.
//   Buffering: strobe during CRD -> pending, executed after CACK, error stays 0.
// - Error: a and b in the same cycle -> only a executes, monitor_error=1.
//   Dropped strobe: second strobe during JRD -> dropped, error=1.
//   Clear: a err_clr=1 -> error=0.
// - Reset: reset during JWR -> no RAM write, all outputs at reset values next cycle.
//   With OCIMEM_INIT_CLEAR_EN: ready=0 for 256 cycles, then a read of any address returns 0.

Source files
------------

// File: rtl/jtag_dbg_ocimem_ctrl.sv
// Debug-memory controller: JTAG monitor port and CPU Avalon-MM slave sharing one 2^ADDR_W x 32 sync RAM.
// Latency: JTAG read/write 2 cycles to completion; CPU read 3 cycles, CPU write 2 cycles (waitrequest low in CACK).
// Backpressure: cpu_waitrequest stalls the CPU; JTAG wins, one JTAG request is buffered during a CPU access, others dropped (monitor_error).
// Optional build macro OCIMEM_INIT_CLEAR_EN: after reset a CLR state zeroes the whole RAM before going IDLE.
module jtag_dbg_ocimem_ctrl #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    JRD  = 3'd1,
    JWR  = 3'd2,
    CRD  = 3'd3,
    CACK = 3'd4
`ifdef OCIMEM_INIT_CLEAR_EN
    , CLR = 3'd5
`endif
  } state_t;

  typedef enum logic [1:0] {
    REQ_A  = 2'd0,
    REQ_B  = 2'd1,
    REQ_NA = 2'd2
  } req_t;

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  state_t            state, state_nxt;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [31:0]       ram_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;

  // one-deep buffer for a JTAG request arriving while the CPU owns the RAM
  logic              pend_vld;
  req_t              pend_type;
  logic [35:3]       pend_jdo;

  // JTAG write data held for the JWR cycle, so a reset there cancels the write
  logic [31:0]       jwr_dat;
  logic              ready_q;

  logic              any_stb, multi_stb;
  req_t              stb_type;
  req_t              exec_type;
  logic [35:3]       exec_jdo;
  logic [ADDR_W-1:0] exec_addr;

  logic              exec, pend_load, pend_clear, err_set, err_clr;
  logic              mon_a_load, mon_a_inc, mon_d_load, cpu_rd_load, jwr_load;

  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

`ifdef OCIMEM_INIT_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;
`endif

  assign any_stb   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_stb = (take_action_ocimem_a & take_action_ocimem_b) |
                     (take_action_ocimem_a & take_no_action_ocimem_a) |
                     (take_action_ocimem_b & take_no_action_ocimem_a);
  assign stb_type  = take_action_ocimem_a ? REQ_A : (take_action_ocimem_b ? REQ_B : REQ_NA);

  // a buffered request always goes ahead of fresh strobes
  assign exec_type = pend_vld ? pend_type : stb_type;
  assign exec_jdo  = pend_vld ? pend_jdo  : jdo[35:3];
  assign exec_addr = exec_jdo[17 +: ADDR_W];

  assign cpu_waitrequest = (cpu_read | cpu_write) & (state != CACK);

`ifdef OCIMEM_INIT_CLEAR_EN
  assign monitor_ready = ready_q & (state != CLR);
`else
  assign monitor_ready = ready_q;
`endif

  // state register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef OCIMEM_INIT_CLEAR_EN
      state <= CLR;
`else
      state <= IDLE;
`endif
    end else begin
      state <= state_nxt;
    end
  end

  // next state, RAM port mux and register-update strobes
  always_comb begin
    state_nxt   = state;
    ram_we      = 1'b0;
    ram_addr    = MonAReg;
    ram_wdata   = jwr_dat;
    ram_be      = 4'hF;
    exec        = 1'b0;
    pend_load   = 1'b0;
    pend_clear  = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;
    mon_a_load  = 1'b0;
    mon_a_inc   = 1'b0;
    mon_d_load  = 1'b0;
    cpu_rd_load = 1'b0;
    jwr_load    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_vld || any_stb) begin
          exec       = 1'b1;
          pend_clear = pend_vld;
          // with pending in use any fresh strobe is lost; otherwise only extra strobes are
          err_set    = pend_vld ? any_stb : multi_stb;
          case (exec_type)
            REQ_A: begin
              mon_a_load = 1'b1;
              err_clr    = exec_jdo[35];
              if (exec_jdo[34]) begin
                ram_addr  = exec_addr;
                state_nxt = JRD;
              end
            end
            REQ_B: begin
              jwr_load  = 1'b1;
              state_nxt = JWR;
            end
            default: state_nxt = JRD;
          endcase
        end else if (cpu_read) begin
          ram_addr  = cpu_address;
          state_nxt = CRD;
        end else if (cpu_write) begin
          ram_we    = 1'b1;
          ram_addr  = cpu_address;
          ram_wdata = cpu_writedata;
          ram_be    = cpu_byteenable;
          state_nxt = CACK;
        end
      end
      JRD: begin
        mon_d_load = 1'b1;
        mon_a_inc  = 1'b1;
        err_set    = any_stb;
        state_nxt  = IDLE;
      end
      JWR: begin
        ram_we    = 1'b1;
        mon_a_inc = 1'b1;
        err_set   = any_stb;
        state_nxt = IDLE;
      end
      CRD, CACK: begin
        if (state == CRD) begin
          cpu_rd_load = 1'b1;
          state_nxt   = CACK;
        end else begin
          state_nxt = IDLE;
        end
        if (any_stb) begin
          if (pend_vld) begin
            err_set = 1'b1;
          end else begin
            pend_load = 1'b1;
            err_set   = multi_stb;
          end
        end
      end
`ifdef OCIMEM_INIT_CLEAR_EN
      CLR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = '0;
        err_set   = any_stb;
        if (clr_cnt == '1) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // single-port RAM: byte-lane write, 1-cycle registered read; writes blocked during reset
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    ram_q <= mem[ram_addr];
  end

  // JTAG-visible registers, CPU read data, pending buffer and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      MonDReg       <= '0;
      MonAReg       <= RESET_ADDR;
      ready_q       <= 1'b1;
      monitor_error <= 1'b0;
      cpu_readdata  <= '0;
      pend_vld      <= 1'b0;
      pend_type     <= REQ_A;
      pend_jdo      <= '0;
      jwr_dat       <= '0;
    end else begin
      if (mon_a_load)     MonAReg <= exec_addr;
      else if (mon_a_inc) MonAReg <= MonAReg + A_ONE;
      if (mon_d_load)  MonDReg      <= ram_q;
      if (cpu_rd_load) cpu_readdata <= ram_q;
      if (jwr_load)    jwr_dat      <= exec_jdo[34:3];
      if (pend_load) begin
        pend_vld  <= 1'b1;
        pend_type <= stb_type;
        pend_jdo  <= jdo[35:3];
      end else if (pend_clear) begin
        pend_vld <= 1'b0;
      end
      if (err_set)      monitor_error <= 1'b1;
      else if (err_clr) monitor_error <= 1'b0;
      if (exec || pend_load)                                   ready_q <= 1'b0;
      else if (state == IDLE || state == JRD || state == JWR)  ready_q <= 1'b1;
    end
  end

`ifdef OCIMEM_INIT_CLEAR_EN
  // address sweep for the post-reset clear
  always_ff @(posedge clk) begin
    if (reset)               clr_cnt <= '0;
    else if (state == CLR)   clr_cnt <= clr_cnt + A_ONE;
  end
`endif

endmodule
